// File: rtl/max7219_pkg.sv
// Shared MAX7219 definitions: register addresses, sequencer state type and
// the 16-bit serial frame builder.
package max7219_pkg;

  localparam logic [3:0] C_REG_NOOP      = 4'h0;
  localparam logic [3:0] C_REG_DIGIT0    = 4'h1;
  localparam logic [3:0] C_REG_DIGIT1    = 4'h2;
  localparam logic [3:0] C_REG_DIGIT2    = 4'h3;
  localparam logic [3:0] C_REG_DIGIT3    = 4'h4;
  localparam logic [3:0] C_REG_DIGIT4    = 4'h5;
  localparam logic [3:0] C_REG_DIGIT5    = 4'h6;
  localparam logic [3:0] C_REG_DIGIT6    = 4'h7;
  localparam logic [3:0] C_REG_DIGIT7    = 4'h8;
  localparam logic [3:0] C_REG_DECODE    = 4'h9;
  localparam logic [3:0] C_REG_INTENSITY = 4'hA;
  localparam logic [3:0] C_REG_SCAN      = 4'hB;
  localparam logic [3:0] C_REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] C_REG_TEST      = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_FINISH
  } seq_state_t;

  function automatic logic [15:0] max7219_frame(input logic [3:0] addr,
                                                input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_cfg_seq.sv
// Power-up configuration sequencer for a chain of MAX7219 drivers: sends each
// configuration command once per chained device, loading on the last frame.
module max7219_cfg_seq
  import max7219_pkg::*;
#(
  parameter int G_NB_MATRIX = 8,
  parameter int G_TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_display_test,
  input  logic [7:0]  i_decode_mode,
  input  logic [3:0]  i_intensity,
  input  logic [2:0]  i_scan_limit,
  input  logic        i_clear,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  input  logic        i_max7219_if_done,
  output logic        o_max7219_if_start,
  output logic        o_max7219_if_en_load,
  output logic [15:0] o_max7219_if_data,
  output seq_state_t  dbg_state
);

  // Handshake with max7219_if: o_max7219_if_start is a one-cycle request with
  // data/en_load valid in that cycle and held until the next request; the
  // frame completes on a one-cycle i_max7219_if_done pulse, which is only
  // honoured while waiting for it.
  localparam logic [3:0]  C_MAT_LAST = 4'(G_NB_MATRIX - 1);
  localparam logic [15:0] C_TMO_LAST = 16'(G_TIMEOUT - 1);
  localparam logic [3:0]  C_CMD_SCAN = 4'd3;
  localparam logic [3:0]  C_CMD_LAST = 4'd12;

  seq_state_t  state;
  logic [3:0]  cmd_idx;
  logic [3:0]  mat_cnt;
  logic [15:0] timer;
  logic        test_q;
  logic [7:0]  decode_q;
  logic [3:0]  intensity_q;
  logic [2:0]  scan_q;
  logic        clear_q;
  logic [15:0] cmd_frame;

  assign dbg_state = state;

  always_comb begin
    cmd_frame = max7219_frame(C_REG_NOOP, 8'h00);
    case (cmd_idx)
      4'd0:  cmd_frame = max7219_frame(C_REG_TEST, {7'h00, test_q});
      4'd1:  cmd_frame = max7219_frame(C_REG_DECODE, decode_q);
      4'd2:  cmd_frame = max7219_frame(C_REG_INTENSITY, {4'h0, intensity_q});
      4'd3:  cmd_frame = max7219_frame(C_REG_SCAN, {5'h00, scan_q});
      // Indices 4..11 map onto digit registers 0x01..0x08.
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:
        cmd_frame = max7219_frame(cmd_idx - 4'd3, 8'h00);
      4'd12: cmd_frame = max7219_frame(C_REG_SHUTDOWN, 8'h01);
      default: cmd_frame = max7219_frame(C_REG_NOOP, 8'h00);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      cmd_idx              <= 4'd0;
      mat_cnt              <= 4'd0;
      timer                <= 16'd0;
      test_q               <= 1'b0;
      decode_q             <= 8'h00;
      intensity_q          <= 4'h0;
      scan_q               <= 3'd0;
      clear_q              <= 1'b0;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
      o_error              <= 1'b0;
      o_max7219_if_start   <= 1'b0;
      o_max7219_if_en_load <= 1'b0;
      o_max7219_if_data    <= 16'h0000;
    end else begin
      o_max7219_if_start <= 1'b0;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            test_q      <= i_display_test;
            decode_q    <= i_decode_mode;
            intensity_q <= i_intensity;
            scan_q      <= i_scan_limit;
            clear_q     <= i_clear;
            cmd_idx     <= 4'd0;
            mat_cnt     <= 4'd0;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          o_busy               <= 1'b1;
          o_max7219_if_start   <= 1'b1;
          o_max7219_if_data    <= cmd_frame;
          o_max7219_if_en_load <= (mat_cnt == C_MAT_LAST);
          timer                <= 16'd0;
          state                <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_max7219_if_done) begin
            state <= ST_NEXT;
          end else if (timer >= C_TMO_LAST) begin
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end else if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
          end
        end
        ST_NEXT: begin
          if (mat_cnt == C_MAT_LAST) begin
            mat_cnt <= 4'd0;
            if (cmd_idx == C_CMD_LAST) begin
              state <= ST_FINISH;
            end else begin
              // Without a clear the digit writes are skipped entirely.
              cmd_idx <= (cmd_idx == C_CMD_SCAN && !clear_q) ? C_CMD_LAST
                                                             : cmd_idx + 4'd1;
              state   <= ST_SEND;
            end
          end else begin
            mat_cnt <= mat_cnt + 4'd1;
            state   <= ST_SEND;
          end
        end
        ST_FINISH: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_cfg_seq.sv
// Bench for max7219_cfg_seq: deadline-based reference model with per-cycle
// compare, a daisy-chain register model, and a single-device frame check.
module tb_max7219_cfg_seq;
  import max7219_pkg::*;

  localparam int N = 8;
  localparam int T = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, done8 = 1'b0, start1 = 1'b0, done1 = 1'b0;
  logic        tst = 1'b0, clr = 1'b0;
  logic [7:0]  dec = 8'h00;
  logic [3:0]  inten = 4'h0;
  logic [2:0]  scan = 3'd0;
  logic        busy8, odone8, err8, ifs8, en8;
  logic        busy1, odone1, err1, ifs1, en1;
  logic [15:0] data8, data1;
  seq_state_t  st8, st1;

  int checks = 0;
  int errors = 0;

  max7219_cfg_seq #(.G_NB_MATRIX(N), .G_TIMEOUT(T)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(start8), .i_display_test(tst),
    .i_decode_mode(dec), .i_intensity(inten), .i_scan_limit(scan),
    .i_clear(clr), .o_busy(busy8), .o_done(odone8), .o_error(err8),
    .i_max7219_if_done(done8), .o_max7219_if_start(ifs8),
    .o_max7219_if_en_load(en8), .o_max7219_if_data(data8), .dbg_state(st8)
  );

  max7219_cfg_seq #(.G_NB_MATRIX(1), .G_TIMEOUT(1000)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_display_test(tst),
    .i_decode_mode(dec), .i_intensity(inten), .i_scan_limit(scan),
    .i_clear(clr), .o_busy(busy1), .o_done(odone1), .o_error(err1),
    .i_max7219_if_done(done1), .o_max7219_if_start(ifs1),
    .o_max7219_if_en_load(en1), .o_max7219_if_data(data1), .dbg_state(st1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: expected frame queue plus absolute-cycle deadlines
  logic [16:0] exp_q[$];
  longint cyc = 0, start_at = -1, done_at = -1, err_at = -1;
  bit     m_active = 0, m_wait = 0, was_active = 0;
  logic   exp_start = 0, exp_done = 0, exp_error = 0, exp_busy = 0, m_en = 0;
  logic [15:0] m_data = 16'h0;

  task automatic build_frames(input logic c, input logic t, input logic [7:0] d,
                              input logic [3:0] i, input logic [2:0] s);
    logic [3:0] a;
    logic [7:0] v;
    exp_q.delete();
    for (int k = 0; k < 13; k++) begin
      if (!c && k >= 4 && k <= 11) continue;
      case (k)
        0:  begin a = 4'hF; v = {7'd0, t}; end
        1:  begin a = 4'h9; v = d; end
        2:  begin a = 4'hA; v = {4'd0, i}; end
        3:  begin a = 4'hB; v = {5'd0, s}; end
        12: begin a = 4'hC; v = 8'h01; end
        default: begin a = 4'(k - 3); v = 8'h00; end
      endcase
      for (int m = 0; m < N; m++) exp_q.push_back({(m == N - 1), 4'h0, a, v});
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_wait = 0; start_at = -1; done_at = -1; err_at = -1;
      exp_start = 0; exp_done = 0; exp_error = 0; exp_busy = 0;
      m_en = 0; m_data = 16'h0; exp_q.delete();
    end else begin
      cyc++;
      exp_start = 0; exp_done = 0; exp_error = 0;
      was_active = m_active;
      if (m_wait && done8) begin
        m_wait = 0;
        if (exp_q.size() == 0) done_at = cyc + 2;
        else start_at = cyc + 2;
      end else if (m_wait && cyc == err_at) begin
        m_wait = 0; m_active = 0; exp_error = 1; exp_busy = 0; exp_q.delete();
      end
      if (cyc == start_at) begin
        {m_en, m_data} = exp_q.pop_front();
        exp_start = 1; exp_busy = 1; m_wait = 1; err_at = cyc + T; start_at = -1;
      end
      if (cyc == done_at) begin
        exp_done = 1; exp_busy = 0; m_active = 0; done_at = -1;
      end
      if (!was_active && start8) begin
        m_active = 1;
        build_frames(clr, tst, dec, inten, scan);
        start_at = cyc + 1;
      end
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    chk("busy", busy8, exp_busy);
    chk("if_start", ifs8, exp_start);
    chk("done", odone8, exp_done);
    chk("error", err8, exp_error);
    chk("en_load", en8, m_en);
    chk("data", data8, m_data);
  end

  // max7219_if responder and daisy-chain register model
  bit          resp_en = 0;
  int          pend = -1, dly;
  int          starts8 = 0, loads8 = 0, done_cnt8 = 0;
  logic [15:0] sh [0:N-1];
  logic [7:0]  regs [0:N-1][0:15];

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = -1; done8 = 0;
    end else begin
      done8 = 0;
      if (pend == 0) begin done8 = 1; pend = -1; end
      else if (pend > 0) pend--;
      if (ifs8) begin
        starts8++;
        for (int k = N - 1; k > 0; k--) sh[k] = sh[k-1];
        sh[0] = data8;
        if (en8) begin
          loads8++;
          for (int k = 0; k < N; k++) regs[k][sh[k][11:8]] = sh[k][7:0];
        end
        if (resp_en) begin
          dly = $urandom_range(0, 3);
          if (dly == 0) done8 = 1; else pend = dly - 1;
        end
      end else if (resp_en && !busy8 && pend < 0 && $urandom_range(0, 7) == 0) begin
        done8 = 1;  // stray pulse while idle must be ignored
      end
      if (odone8) done_cnt8++;
    end
  end

  logic [16:0] q1[$];
  always @(negedge clk) begin
    if (!rst_n) done1 = 0;
    else begin
      done1 = ifs1;
      if (ifs1) q1.push_back({en1, data1});
    end
  end

  // driver tasks
  task automatic run8(input logic c, input logic t, input logic [7:0] d,
                      input logic [3:0] i, input logic [2:0] s, input bit poke);
    int n;
    @(negedge clk);
    clr = c; tst = t; dec = d; inten = i; scan = s; start8 = 1;
    @(negedge clk);
    start8 = 0;
    clr = 1'($urandom); tst = 1'($urandom); dec = 8'($urandom);
    inten = 4'($urandom); scan = 3'($urandom);
    n = 0;
    while (!(odone8 || err8) && n < 5000) begin
      @(negedge clk);
      n++;
      start8 = 0;
      if (poke && busy8 && $urandom_range(0, 15) == 0) start8 = 1;
      if (poke && done_at == cyc + 1) start8 = 1;
    end
    start8 = 0;
    chk("run_completes", (n < 5000), 1'b1);
  endtask

  task automatic check_regs(input logic c, input logic t, input logic [7:0] d,
                            input logic [3:0] i, input logic [2:0] s);
    int nz;
    nz = 0;
    for (int k = 0; k < N; k++) begin
      chk("reg_test", regs[k][15], {7'd0, t});
      chk("reg_decode", regs[k][9], d);
      chk("reg_intensity", regs[k][10], {4'd0, i});
      chk("reg_scan", regs[k][11], {5'd0, s});
      chk("reg_shutdown", regs[k][12], 8'h01);
      for (int g = 1; g <= 8; g++) if (regs[k][g] != 8'h00) nz++;
    end
    if (c) chk("digits_nonzero", nz, 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int b, l, dn, n;
    logic c, t;
    logic [7:0] d;
    logic [3:0] i;
    logic [2:0] s;
    logic [15:0] exp1 [0:4];
    exp1[0] = 16'h0F00; exp1[1] = 16'h0900; exp1[2] = 16'h0A05;
    exp1[3] = 16'h0B07; exp1[4] = 16'h0C01;
    for (int k = 0; k < N; k++) begin
      sh[k] = 16'h0;
      for (int a = 0; a < 16; a++) regs[k][a] = 8'hEE;
    end

    repeat (3) @(negedge clk);
    chk("rst_state", st8, ST_IDLE);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_data", data8, 16'h0);
    rst_n = 1;
    resp_en = 1;

    // clear=0 with repeated starts while busy and in the finish cycle
    b = starts8; l = loads8; dn = done_cnt8;
    run8(1'b0, 1'b0, 8'h00, 4'h5, 3'd7, 1'b1);
    repeat (10) @(negedge clk);
    chk("a_starts", starts8 - b, 40);
    chk("a_loads", loads8 - l, 5);
    chk("a_done_once", done_cnt8 - dn, 1);
    chk("a_idle_after", busy8, 1'b0);
    check_regs(1'b0, 1'b0, 8'h00, 4'h5, 3'd7);

    // clear=1 over pre-filled digits
    for (int k = 0; k < N; k++) for (int g = 1; g <= 8; g++) regs[k][g] = 8'hFF;
    b = starts8; l = loads8;
    i = 4'($urandom);
    run8(1'b1, 1'b1, 8'hFF, i, 3'd3, 1'b0);
    repeat (10) @(negedge clk);
    chk("b_starts", starts8 - b, 104);
    chk("b_loads", loads8 - l, 13);
    check_regs(1'b1, 1'b1, 8'hFF, i, 3'd3);

    // timeout with done held low
    resp_en = 0;
    b = starts8;
    @(negedge clk);
    clr = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    n = 0;
    while (!ifs8 && n < 10) begin @(negedge clk); n++; end
    chk("tmo_first_start", ifs8, 1'b1);
    n = 0;
    while (!err8 && n < 100) begin @(negedge clk); n++; end
    chk("tmo_latency", n, 20);
    repeat (30) @(negedge clk);
    #1;
    chk("tmo_busy", busy8, 1'b0);
    chk("tmo_starts", starts8 - b, 1);
    resp_en = 1;
    b = starts8;
    run8(1'b0, 1'b0, 8'h0F, 4'hA, 3'd5, 1'b0);
    repeat (10) @(negedge clk);
    chk("retry_starts", starts8 - b, 40);

    // asynchronous reset during the 17th frame
    b = starts8;
    @(negedge clk);
    clr = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    n = 0;
    while (starts8 - b < 17 && n < 2000) begin @(negedge clk); #1; n++; end
    chk("rst_reach_17", starts8 - b, 17);
    rst_n = 0;
    #1;
    chk("arst_busy", busy8, 1'b0);
    chk("arst_start", ifs8, 1'b0);
    chk("arst_done", odone8, 1'b0);
    chk("arst_error", err8, 1'b0);
    chk("arst_en_load", en8, 1'b0);
    chk("arst_data", data8, 16'h0);
    @(negedge clk);
    #1 rst_n = 1;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_no_more_starts", starts8 - b, 17);
    b = starts8;
    run8(1'b0, 1'b1, 8'h3C, 4'h2, 3'd1, 1'b0);
    repeat (10) @(negedge clk);
    chk("post_rst_starts", starts8 - b, 40);

    // random runs
    for (int r = 0; r < 4; r++) begin
      c = 1'($urandom); t = 1'($urandom); d = 8'($urandom);
      i = 4'($urandom); s = 3'($urandom);
      for (int k = 0; k < N; k++) for (int g = 1; g <= 8; g++) regs[k][g] = 8'($urandom);
      b = starts8; l = loads8; dn = done_cnt8;
      run8(c, t, d, i, s, 1'b1);
      repeat (10) @(negedge clk);
      chk("rnd_starts", starts8 - b, c ? 104 : 40);
      chk("rnd_loads", loads8 - l, c ? 13 : 5);
      chk("rnd_done_once", done_cnt8 - dn, 1);
      check_regs(c, t, d, i, s);
    end

    // single device, immediate done: 16 edges from accept to o_done
    q1.delete();
    @(negedge clk);
    clr = 0; tst = 0; dec = 8'h00; inten = 4'h5; scan = 3'd7; start1 = 1;
    @(negedge clk);
    start1 = 0;
    n = 0;
    while (!odone1 && n < 500) begin @(negedge clk); n++; end
    chk("n1_run_edges", n, 16);
    repeat (3) @(negedge clk);
    chk("n1_frame_count", q1.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < q1.size()) begin
        chk("n1_frame", q1[k][15:0], exp1[k]);
        chk("n1_en_load", q1[k][16], 1'b1);
      end
    end
    chk("n1_error", err1, 1'b0);
    chk("n1_busy", busy1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_cfg_seq.md
# max7219_cfg_seq

Power-up configuration sequencer for a daisy-chain of MAX7219 LED-matrix drivers. On a start request it walks a fixed list of configuration commands (display test, decode mode, intensity, scan limit, optional digit clear, normal-operation exit from shutdown). It issues each command once per chained matrix through the shared `max7219_if` serial interface, asserting the load enable only on the last frame of each command. It sits upstream of `max7219_if`, ahead of `max7219_cmd_decod`, and drives the interface until configuration completes.

## Interface
- `G_NB_MATRIX`, 8: number of daisy-chained MAX7219 devices, 1..16.
- `G_TIMEOUT`, 1000: max cycles to wait for `i_max7219_if_done` per frame, 1..65535.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: one-cycle request; sampled only in IDLE.
- `i_display_test` in 1: data written to register 0x0F.
- `i_decode_mode` in 8: data written to register 0x09.
- `i_intensity` in 4: data written to register 0x0A, as {4'h0, i_intensity}.
- `i_scan_limit` in 3: data written to register 0x0B, as {5'h0, i_scan_limit}.
- `i_clear` in 1: 1 means write 0x00 to digit registers 0x01..0x08.
- `o_busy` out 1: high from the cycle after `i_start` is accepted until `o_done`.
- `o_done` out 1: one-cycle pulse at successful completion.
- `o_error` out 1: one-cycle pulse on timeout; the sequence is aborted.
- `i_max7219_if_done` in 1: one-cycle frame-complete pulse from `max7219_if`.
- `o_max7219_if_start` out 1: one-cycle frame request.
- `o_max7219_if_en_load` out 1: load enable for the frame being requested.
- `o_max7219_if_data` out 16: frame, {4'h0, addr[3:0], data[7:0]}.

## Operation
- Reset: every output is 0, all counters are 0, and the FSM is in IDLE. Reset is immediate; if it is asserted mid-sequence, no further start is emitted.
- Inputs `i_display_test`, `i_decode_mode`, `i_intensity`, `i_scan_limit` and `i_clear` are latched on the accepted `i_start`. Later changes have no effect until the next run.
- Command list, indexed by `cmd_idx`:
  - 0: reg 0x0F, data test.
  - 1: reg 0x09, data decode.
  - 2: reg 0x0A, data intensity.
  - 3: reg 0x0B, data scan limit.
  - 4..11: reg 0x01..0x08, data 0x00.
  - 12: reg 0x0C, data 0x01.
- When `i_clear`=0, indices 4..11 are skipped (3 → 12).
- For each command, `mat_cnt` runs 0..G_NB_MATRIX-1. One frame is sent per count. `o_max7219_if_en_load`=1 only when `mat_cnt`=G_NB_MATRIX-1.
- FSM states: IDLE, SEND, WAIT_DONE, NEXT, FINISH.
  - IDLE→SEND when `i_start`=1.
  - SEND→WAIT_DONE unconditionally; this is the cycle in which the start pulse is output.
  - WAIT_DONE→NEXT when `i_max7219_if_done`=1.
  - WAIT_DONE→IDLE when the timer reaches G_TIMEOUT; `o_error` pulses.
  - NEXT→SEND when frames remain.
  - NEXT→FINISH after the last frame of command 12.
  - FINISH→IDLE; `o_done` pulses.
- `i_start` is ignored in every state except IDLE. This includes FINISH: a start coinciding with `o_done` is dropped.
- A `i_max7219_if_done` pulse outside WAIT_DONE is ignored.
- The timer is 16 bits. It clears on entry to WAIT_DONE and saturates; it does not wrap.
- Frame counts:
  - `i_clear`=1: 13×G_NB_MATRIX starts, 13 loads.
  - `i_clear`=0: 5×G_NB_MATRIX starts, 5 loads.

## Timing
- All outputs are registered.
- `i_start` sampled at edge k gives `o_busy`=1 and `o_max7219_if_start`=1 after edge k+1.
- `o_max7219_if_data` and `o_max7219_if_en_load` are valid in the start cycle and held stable until the next start.
- `i_max7219_if_done` sampled at edge n gives the next start pulse after edge n+2, a fixed one-cycle gap.
- Last done sampled at edge n gives `o_done`=1 after edge n+2 for exactly one cycle. `o_busy` falls at that same edge.
- Timeout gives `o_error` for one cycle, and `o_busy` falls at that same edge.
- Minimum run time for G_NB_MATRIX=1, `i_clear`=0 with immediate done: 5 frames × 3 cycles + 2 cycles.

## Structure
- Shared package `max7219_pkg`:
  - Register-address constants C_REG_NOOP, C_REG_DIGIT0..7, C_REG_DECODE, C_REG_INTENSITY, C_REG_SCAN, C_REG_SHUTDOWN, C_REG_TEST.
  - FSM enum type.
  - Function `max7219_frame(addr, data)` that returns the 16-bit frame.
- No sub-module. The command list is a `case` on `cmd_idx` inside the block.
- Top-level mux: during `o_busy`, the sequencer's start, data and en_load are routed to `max7219_if` instead of `max7219_cmd_decod`'s.

## Test plan
- G_NB_MATRIX=8, `i_clear`=0, intensity=0x5, scan=7, decode=0x00, test=0, with `max7219_if` instantiated.
  - Required: 40 starts and 5 loads.
  - Checker matrices hold reg 0x0A=0x05, 0x0B=0x07, 0x0C=0x01.
  - `o_done` fires once.
- `i_clear`=1, digits pre-filled with 0xFF: 104 starts; all 8 digit registers of all 8 matrices read 0x00 after `o_done`.
- `i_start` pulsed again while busy and in the FINISH cycle: no second run; the start count stays 40.
- `i_max7219_if_done` held low, G_TIMEOUT=20:
  - `o_error` pulses 20 cycles after the first start.
  - `o_busy`=0 and no further starts follow.
  - A subsequent `i_start` restarts from `cmd_idx`=0.
- `rst_n` asserted during the 17th frame: all outputs are 0 asynchronously. After release, one `i_start` runs a complete 40-frame sequence.
- G_NB_MATRIX=1: `o_max7219_if_en_load`=1 on every frame; 5 starts; frames are 0x0F00, 0x0900, 0x0A05, 0x0B07, 0x0C01.
